load_store_unit: RTL and testbench
==================================

# load_store_unit

Memory-access stage directly downstream of the ALU. Takes the ALU result as the effective address and rs2 as store data, drives a simple request/ready data bus with byte enables, and returns sign- or zero-extended load data to the write-back mux. It stalls the core while a bus transaction is outstanding and flags misaligned or illegal accesses without issuing a bus cycle.

## Interface
- TIMEOUT_CYCLES, 255: REQ cycles without BusReady before abort (only with LSU_TIMEOUT_EN); range 1..255.
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- Addr  in  32  effective address (ALUResult)
- WriteData  in  32  store data (rs2)
- Funct3  in  3  access size/sign: 000 b, 001 h, 010 w, 100 bu, 101 hu (loads); 000/001/010 stores
- MemRead  in  1  load request; held stable by core while Stall=1
- MemWrite  in  1  store request; held stable by core while Stall=1
- ReadData  out  32  extended load data, valid in DONE cycle
- Stall  out  1  freeze PC/pipeline
- Fault  out  1  misaligned/illegal/timeout indication
- BusReq  out  1  bus request, registered
- BusWe  out  1  1 = write
- BusAddr  out  32  word-aligned address ({Addr[31:2],2'b00})
- BusWData  out  32  lane-replicated store data
- BusBe  out  4  byte enables
- BusReady  in  1  slave completes the access in the cycle it is sampled high
- BusRData  in  32  read data, valid when BusReady=1

## Operation
- FSM states: IDLE, REQ, DONE. Reset -> IDLE.
- Access = MemRead ^ MemWrite. MemRead & MemWrite both high = illegal.
- Illegal: both requests high; load Funct3 in {011,110,111}; store Funct3 not in {000,001,010}.
- Misaligned: halfword with Addr[0]=1; word with Addr[1:0]!=00.
- IDLE, Access, legal, aligned: latch BusAddr/BusWe/BusWData/BusBe and byte offset/Funct3; next REQ.
- IDLE, illegal or misaligned: Fault=1 combinationally, Stall=0, no bus cycle, ReadData unchanged, stay IDLE.
- REQ: BusReq=1. On BusReady=1: capture BusRData into ReadData (extended), next DONE, BusReq clears.
- DONE: Stall=0, one cycle; next IDLE unconditionally.
- BusBe: byte = 0001<<Addr[1:0]; half = 0011<<{Addr[1],0}; word = 1111.
- BusWData: byte replicated to 4 lanes, half to 2 lanes, word as is.
- Load extraction: select lane by latched offset; lb/lh sign-extend from bit 7/15, lbu/lhu zero-extend, lw raw.
- Stores: ReadData not updated.

## Timing
- Stall = (IDLE & Access & legal & aligned) | REQ. DONE and faulting cycles: Stall=0.
- Minimum latency 3 cycles (IDLE, REQ with BusReady, DONE); each cycle BusReady is low adds one REQ cycle.
- Bus outputs registered; stable throughout REQ. BusReady ignored outside REQ.
- Reset values: state IDLE, BusReq 0, BusWe 0, BusAddr 0, BusWData 0, BusBe 0000, ReadData 0, Fault 0, Stall 0, timeout counter 0.
- Reset mid-transaction: BusReq drops asynchronously, FSM to IDLE, no completion, ReadData 0.
- BusReady high on entering REQ's first cycle is honoured (zero wait states).

## Configuration
- LSU_TIMEOUT_EN defined: 8-bit counter cleared entering REQ, increments each REQ cycle with BusReady=0; when count reaches TIMEOUT_CYCLES, BusReq drops, FSM -> DONE with Fault=1 (registered) and ReadData=0.
- Undefined: no counter; REQ waits indefinitely for BusReady; Fault never set in DONE.

## Test plan
- lw Addr=0x100, BusRData=0xDEADBEEF, BusReady after 2 wait cycles -> BusBe=1111, Stall high 4 cycles, DONE ReadData=0xDEADBEEF.
- lb Addr=0x103, BusRData=0x80112233 -> BusAddr=0x100, ReadData=0xFFFFFF80; lbu same -> 0x00000080.
- sh Addr=0x202, WriteData=0x0000ABCD -> BusWe=1, BusBe=1100, BusWData=0xABCDABCD; ReadData unchanged.
- lw Addr=0x101 -> Fault=1 same cycle, Stall=0, BusReq never asserted; MemRead&MemWrite both high -> same.
- rst_n low during REQ -> BusReq 0 immediately, all outputs at reset values, next lw completes normally.
- LSU_TIMEOUT_EN, TIMEOUT_CYCLES=4, BusReady stuck 0 -> BusReq drops after 4 REQ cycles, DONE with Fault=1, ReadData=0.

Source files
------------

// File: rtl/load_store_unit.sv
// load_store_unit: memory-access stage driving a req/ready data bus with byte enables and extended load return.
module load_store_unit #(parameter int TIMEOUT_CYCLES = 255) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  input  logic [2:0]  Funct3,
  input  logic        MemRead,
  input  logic        MemWrite,
  output logic [31:0] ReadData,
  output logic        Stall,
  output logic        Fault,
  output logic        BusReq,
  output logic        BusWe,
  output logic [31:0] BusAddr,
  output logic [31:0] BusWData,
  output logic [3:0]  BusBe,
  input  logic        BusReady,
  input  logic [31:0] BusRData
);
  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
  state_t r_state, w_next;
  logic r_bus_req, r_bus_we;
  logic [31:0] r_bus_addr, r_bus_wdata, r_rdata;
  logic [3:0] r_bus_be;
  logic [1:0] r_off;
  logic [2:0] r_f3;
  logic w_access, w_illegal, w_misaligned, w_go, w_idle_fault, w_complete, w_abort, w_done_fault;
  logic [3:0] w_be;
  logic [31:0] w_wdata, w_ext;
  logic [15:0] w_lane;
  assign w_access = MemRead ^ MemWrite;
  assign w_illegal = (MemRead & MemWrite)
                   | (MemRead & ((Funct3 == 3'b011) | (Funct3[2:1] == 2'b11)))
                   | (MemWrite & (Funct3[2] | (Funct3[1:0] == 2'b11)));
  assign w_misaligned = ((Funct3[1:0] == 2'b01) & Addr[0]) | ((Funct3[1:0] == 2'b10) & (Addr[1:0] != 2'b00));
  assign w_idle_fault = (r_state == IDLE) & (MemRead | MemWrite) & (w_illegal | w_misaligned);
  assign w_go = (r_state == IDLE) & w_access & ~w_illegal & ~w_misaligned;
  assign w_complete = (r_state == REQ) & BusReady;
  assign w_be = (Funct3[1:0] == 2'b00) ? 4'b0001 << Addr[1:0] :
                (Funct3[1:0] == 2'b01) ? 4'b0011 << {Addr[1], 1'b0} : 4'b1111;
  assign w_wdata = (Funct3[1:0] == 2'b00) ? {4{WriteData[7:0]}} :
                   (Funct3[1:0] == 2'b01) ? {2{WriteData[15:0]}} : WriteData;
  assign w_lane = 16'(BusRData >> {r_off, 3'b000});
  assign w_ext = (r_f3 == 3'b000) ? {{24{w_lane[7]}}, w_lane[7:0]} :
                 (r_f3 == 3'b100) ? {24'd0, w_lane[7:0]} :
                 (r_f3 == 3'b001) ? {{16{w_lane[15]}}, w_lane[15:0]} :
                 (r_f3 == 3'b101) ? {16'd0, w_lane[15:0]} : BusRData;
`ifdef LSU_TIMEOUT_EN
  logic [7:0] r_cnt;
  logic r_fault;
  assign w_abort = (r_state == REQ) & ~BusReady & (r_cnt == 8'(TIMEOUT_CYCLES - 1));
  assign w_done_fault = r_fault;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_fault <= 1'b0;
    end else begin
      if (w_go) r_cnt <= '0;
      else if ((r_state == REQ) & ~BusReady) r_cnt <= r_cnt + 8'd1;
      r_fault <= w_abort;
    end
  end
`else
  assign w_abort = 1'b0;
  assign w_done_fault = 1'b0;
`endif
  always_comb begin
    w_next = r_state;
    Stall = rst_n & (w_go | (r_state == REQ));
    Fault = rst_n & (w_idle_fault | ((r_state == DONE) & w_done_fault));
    case (r_state)
      IDLE: w_next = w_go ? REQ : IDLE;
      REQ:  w_next = (w_complete | w_abort) ? DONE : REQ;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_bus_req <= 1'b0;
      r_bus_we <= 1'b0;
      r_bus_addr <= '0;
      r_bus_wdata <= '0;
      r_bus_be <= '0;
      r_off <= '0;
      r_f3 <= '0;
      r_rdata <= '0;
    end else begin
      r_state <= w_next;
      if (w_go) begin
        r_bus_req <= 1'b1;
        r_bus_we <= MemWrite;
        r_bus_addr <= {Addr[31:2], 2'b00};
        r_bus_wdata <= w_wdata;
        r_bus_be <= w_be;
        r_off <= Addr[1:0];
        r_f3 <= Funct3;
      end else if (w_complete | w_abort) r_bus_req <= 1'b0;
      if (w_complete & ~r_bus_we) r_rdata <= w_ext;
      else if (w_abort) r_rdata <= '0;
    end
  end
  assign ReadData = r_rdata;
  assign BusReq = r_bus_req;
  assign BusWe = r_bus_we;
  assign BusAddr = r_bus_addr;
  assign BusWData = r_bus_wdata;
  assign BusBe = r_bus_be;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: scoreboard bench for load_store_unit with a wait-state bus slave model.
module tb_load_store_unit;
  logic clk = 1'b0, rst_n = 1'b0;
  logic [31:0] Addr = '0, WriteData = '0, BusRData = '0;
  logic [2:0] Funct3 = '0;
  logic MemRead = 1'b0, MemWrite = 1'b0, BusReady = 1'b0;
  logic [31:0] ReadData, BusAddr, BusWData;
  logic Stall, Fault, BusReq, BusWe;
  logic [3:0] BusBe;
  int n_vec = 0, n_bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_rd = '0;

  always #5 clk = ~clk;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .Addr(Addr), .WriteData(WriteData), .Funct3(Funct3),
    .MemRead(MemRead), .MemWrite(MemWrite), .ReadData(ReadData), .Stall(Stall), .Fault(Fault),
    .BusReq(BusReq), .BusWe(BusWe), .BusAddr(BusAddr), .BusWData(BusWData), .BusBe(BusBe),
    .BusReady(BusReady), .BusRData(BusRData)
  );

  function automatic logic [31:0] ext(input logic [31:0] d, input logic [1:0] a, input logic [2:0] f3);
    logic [7:0] b;
    logic [15:0] h;
    b = d[8*a +: 8];
    h = a[1] ? d[31:16] : d[15:0];
    case (f3)
      3'b000: return {{24{b[7]}}, b};
      3'b100: return {24'd0, b};
      3'b001: return {{16{h[15]}}, h};
      3'b101: return {16'd0, h};
      default: return d;
    endcase
  endfunction

  function automatic logic [3:0] be_of(input logic [1:0] a, input logic [2:0] f3);
    case (f3[1:0])
      2'b00: return 4'b0001 << a;
      2'b01: return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wd_of(input logic [31:0] d, input logic [2:0] f3);
    case (f3[1:0])
      2'b00: return {d[7:0], d[7:0], d[7:0], d[7:0]};
      2'b01: return {d[15:0], d[15:0]};
      default: return d;
    endcase
  endfunction

  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                      input logic [2:0] f3, input logic [31:0] rdata, input int waits);
    int n, rq;
    logic [31:0] exp;
    exp_q.push_back(wr ? exp_rd : ext(rdata, addr[1:0], f3));
    @(negedge clk);
    MemRead = !wr; MemWrite = wr; Addr = addr; WriteData = wd; Funct3 = f3; BusReady = 1'b0;
    #1;
    n = 0; rq = 0;
    while (Stall === 1'b1 && n < 64) begin
      n++;
      if (BusReq === 1'b1) begin
        rq++;
        n_vec++;
        if ({BusWe, BusAddr, BusBe, BusWData} !== {wr, addr & ~32'd3, be_of(addr[1:0], f3), wd_of(wd, f3)} || Fault !== 1'b0) begin
          n_bad++;
          $display("FAIL bus_fields addr=%h: got we=%b a=%h be=%b wd=%h flt=%b, want we=%b a=%h be=%b wd=%h flt=0",
                   addr, BusWe, BusAddr, BusBe, BusWData, Fault, wr, addr & ~32'd3, be_of(addr[1:0], f3), wd_of(wd, f3));
        end
        BusReady = (rq > waits);
        BusRData = BusReady ? rdata : $urandom;
      end
      @(negedge clk); #1;
    end
    BusReady = 1'b0;
    exp = exp_q.pop_front();
    if (!wr) exp_rd = exp;
    n_vec++;
    if (n !== waits + 2) begin
      n_bad++;
      $display("FAIL stall_cycles addr=%h: got %0d, want %0d", addr, n, waits + 2);
    end
    n_vec++;
    if (ReadData !== exp || Fault !== 1'b0 || BusReq !== 1'b0) begin
      n_bad++;
      $display("FAIL done addr=%h f3=%b: got rd=%h flt=%b req=%b, want rd=%h flt=0 req=0", addr, f3, ReadData, Fault, BusReq, exp);
    end
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_vec++;
    if ({ReadData, Stall, Fault, BusReq, BusWe, BusAddr, BusWData, BusBe} !== '0) begin
      n_bad++;
      $display("FAIL reset_values: got rd=%h st=%b f=%b rq=%b we=%b a=%h wd=%h be=%b, want all 0",
               ReadData, Stall, Fault, BusReq, BusWe, BusAddr, BusWData, BusBe);
    end
    @(negedge clk) rst_n = 1'b1;
  endtask

  task automatic test_ready_ignored();
    @(negedge clk) BusReady = 1'b1;
    repeat (3) begin
      @(negedge clk); #1;
      n_vec++;
      if (BusReq !== 1'b0 || Stall !== 1'b0) begin
        n_bad++;
        $display("FAIL ready_idle: got req=%b stall=%b, want 0 0", BusReq, Stall);
      end
    end
    BusReady = 1'b0;
  endtask

  task automatic test_loads();
    xfer(1'b0, 32'h100, '0, 3'b010, 32'hDEADBEEF, 2);
    xfer(1'b0, 32'h103, '0, 3'b000, 32'h80112233, 0);
    xfer(1'b0, 32'h103, '0, 3'b100, 32'h80112233, 1);
    xfer(1'b0, 32'h042, '0, 3'b001, 32'h9ABC1234, 0);
    xfer(1'b0, 32'h040, '0, 3'b101, 32'h1234FEDC, 3);
    xfer(1'b0, 32'h051, '0, 3'b000, 32'h00007F00, 0);
  endtask

  task automatic test_stores();
    xfer(1'b1, 32'h202, 32'h0000ABCD, 3'b001, 32'h11111111, 0);
    xfer(1'b1, 32'h301, 32'h123456A5, 3'b000, 32'h22222222, 1);
    xfer(1'b1, 32'h304, 32'hCAFEF00D, 3'b010, 32'h33333333, 2);
  endtask

  task automatic fault_case(input logic rd, input logic wr, input logic [31:0] addr, input logic [2:0] f3);
    @(negedge clk);
    MemRead = rd; MemWrite = wr; Addr = addr; Funct3 = f3; WriteData = 32'h5A5A5A5A;
    #1;
    n_vec++;
    if (Fault !== 1'b1 || Stall !== 1'b0) begin
      n_bad++;
      $display("FAIL fault_flag rd=%b wr=%b a=%h f3=%b: got fault=%b stall=%b, want 1 0", rd, wr, addr, f3, Fault, Stall);
    end
    repeat (2) begin
      @(negedge clk); #1;
      n_vec++;
      if (BusReq !== 1'b0 || ReadData !== exp_rd) begin
        n_bad++;
        $display("FAIL fault_nobus a=%h: got req=%b rd=%h, want 0 %h", addr, BusReq, ReadData, exp_rd);
      end
    end
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  task automatic test_faults();
    fault_case(1'b1, 1'b0, 32'h101, 3'b010);
    fault_case(1'b1, 1'b1, 32'h100, 3'b010);
    fault_case(1'b1, 1'b0, 32'h203, 3'b101);
    fault_case(1'b1, 1'b0, 32'h100, 3'b011);
    fault_case(1'b0, 1'b1, 32'h100, 3'b100);
    fault_case(1'b0, 1'b1, 32'h102, 3'b010);
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    MemRead = 1'b1; Addr = 32'h300; Funct3 = 3'b010;
    @(negedge clk); #1;
    n_vec++;
    if (BusReq !== 1'b1) begin
      n_bad++;
      $display("FAIL mid_req: got req=%b, want 1", BusReq);
    end
    #2 rst_n = 1'b0;
    #1;
    n_vec++;
    if ({ReadData, Stall, Fault, BusReq, BusWe, BusAddr, BusWData, BusBe} !== '0) begin
      n_bad++;
      $display("FAIL mid_reset: got rd=%h st=%b f=%b rq=%b a=%h be=%b, want all 0", ReadData, Stall, Fault, BusReq, BusAddr, BusBe);
    end
    MemRead = 1'b0;
    exp_rd = '0;
    @(negedge clk) rst_n = 1'b1;
    xfer(1'b0, 32'h300, '0, 3'b010, 32'h0BADF00D, 1);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 10; i++) begin
      logic wr;
      logic [2:0] f3;
      logic [31:0] a;
      wr = 1'($urandom_range(0, 1));
      f3 = wr ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 4));
      if (!wr && f3 == 3'b011) f3 = 3'b100;
      if (!wr && f3 == 3'b100 && i[0]) f3 = 3'b101;
      a = $urandom & 32'h0000FFFF;
      if (f3[1:0] == 2'b01) a[0] = 1'b0;
      if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
      xfer(wr, a, $urandom, f3, $urandom, (i % 3 == 0) ? 0 : int'($urandom_range(0, 3)));
    end
  endtask

`ifdef LSU_TIMEOUT_EN
  task automatic test_timeout();
    int n;
    @(negedge clk);
    MemRead = 1'b1; Addr = 32'h400; Funct3 = 3'b010; BusReady = 1'b0;
    #1;
    n = 0;
    while (Stall === 1'b1 && n < 20) begin
      n++;
      @(negedge clk); #1;
    end
    n_vec++;
    if (n !== 5 || BusReq !== 1'b0 || Fault !== 1'b1 || ReadData !== '0) begin
      n_bad++;
      $display("FAIL timeout: got stall=%0d req=%b flt=%b rd=%h, want 5 0 1 0", n, BusReq, Fault, ReadData);
    end
    exp_rd = '0;
    MemRead = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_ready_ignored();
    test_loads();
    test_stores();
    test_faults();
    test_reset_mid();
    test_back_to_back();
`ifdef LSU_TIMEOUT_EN
    test_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
